// File: rtl/sample_clock_gen_v2.sv
// Sample/shift/symbol strobe generator with a runtime prescaler and packet-rate select.
// Optional SYNC realignment input is enabled by defining SAMPCLK_SYNC_EN.
module sample_clock_gen_v2 #(
  parameter int CNT_W         = 7,
  parameter int DIV_W         = 8,
  parameter int RATE0_TOTAL   = 127,
  parameter int RATE1_TOTAL   = 63,
  parameter int RATE2_TOTAL   = 31,
  parameter int RATE3_TOTAL   = 15,
  parameter int SAMPS_PER_SYM = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [DIV_W-1:0] DIV,
  input  logic [1:0]       RATE,
`ifdef SAMPCLK_SYNC_EN
  input  logic             SYNC,
`endif
  output logic             SAMP,
  output logic             SHIFT,
  output logic             SYM,
  output logic [CNT_W-1:0] SAMP_IDX
);

  localparam int SYM_W = 8;
  localparam logic [CNT_W-1:0] PCNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);
  localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SAMPS_PER_SYM - 1);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             samp_q, samp_d;
  logic             shift_q, shift_d;
  logic             sym_q, sym_d;
  logic [CNT_W-1:0] sel_total;
  logic             sync_w;

`ifdef SAMPCLK_SYNC_EN
  assign sync_w = SYNC;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    sel_total = CNT_W'(RATE0_TOTAL);
    case (RATE)
      2'd0: sel_total = CNT_W'(RATE0_TOTAL);
      2'd1: sel_total = CNT_W'(RATE1_TOTAL);
      2'd2: sel_total = CNT_W'(RATE2_TOTAL);
      2'd3: sel_total = CNT_W'(RATE3_TOTAL);
      default: sel_total = CNT_W'(RATE0_TOTAL);
    endcase
  end

  // Strobes default low; counters and shadows hold unless enabled.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    div_d     = div_q;
    total_d   = total_q;
    pcnt_d    = pcnt_q;
    sym_cnt_d = sym_cnt_q;
    samp_d    = 1'b0;
    shift_d   = 1'b0;
    sym_d     = 1'b0;
    if (ENABLE) begin
      if (sync_w) begin
        pre_cnt_d = '0;
        pcnt_d    = '0;
        sym_cnt_d = '0;
        div_d     = DIV;
        total_d   = sel_total;
      end else if (pre_cnt_q == div_q) begin
        pre_cnt_d = '0;
        if (pcnt_q == total_q - PCNT_ONE) begin
          // Shadows reload only at wrap so a period is never cut short.
          pcnt_d  = '0;
          samp_d  = 1'b1;
          div_d   = DIV;
          total_d = sel_total;
          if (sym_cnt_q == SYM_LAST) begin
            sym_cnt_d = '0;
            sym_d     = 1'b1;
          end else begin
            sym_cnt_d = sym_cnt_q + SYM_ONE;
          end
        end else begin
          pcnt_d  = pcnt_q + PCNT_ONE;
          shift_d = 1'b1;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pre_cnt_q <= '0;
      pcnt_q    <= '0;
      sym_cnt_q <= '0;
      samp_q    <= 1'b0;
      shift_q   <= 1'b0;
      sym_q     <= 1'b0;
      div_q     <= DIV;
      total_q   <= sel_total;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pcnt_q    <= pcnt_d;
      sym_cnt_q <= sym_cnt_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      sym_q     <= sym_d;
      div_q     <= div_d;
      total_q   <= total_d;
    end
  end

  assign SAMP     = samp_q;
  assign SHIFT    = shift_q;
  assign SYM      = sym_q;
  assign SAMP_IDX = pcnt_q;

endmodule

// File: tb/tb_sample_clock_gen_v2.sv
// Scoreboard bench for sample_clock_gen_v2: tick/period model feeds a queue, a monitor compares.
module tb_sample_clock_gen_v2;
  localparam int SPS = 4;
  int TOT[4] = '{127, 63, 31, 15};

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       SYNC = 1'b0;
  logic [7:0] DIV = 8'd0;
  logic [1:0] RATE = 2'd0;
  logic       samp, shift, sym;
  logic [6:0] idx;

  typedef struct {
    bit samp;
    bit shift;
    bit sym;
    int idx;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: clocks into current tick, ticks into current period, samples since reset.
  int m_clk, m_tick, m_samps, m_div, m_total;

  sample_clock_gen_v2 dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .DIV(DIV),
    .RATE(RATE),
`ifdef SAMPCLK_SYNC_EN
    .SYNC(SYNC),
`endif
    .SAMP(samp),
    .SHIFT(shift),
    .SYM(sym),
    .SAMP_IDX(idx)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic void model_step();
    exp_t e;
    bit restart;
    e = '{samp: 1'b0, shift: 1'b0, sym: 1'b0, idx: 0};
    restart = RESET;
`ifdef SAMPCLK_SYNC_EN
    if (ENABLE && SYNC) restart = 1'b1;
`endif
    if (restart) begin
      m_clk = 0; m_tick = 0; m_samps = 0;
      m_div = int'(DIV); m_total = TOT[RATE];
    end else if (ENABLE) begin
      if (m_clk < m_div) m_clk++;
      else begin
        m_clk = 0;
        m_tick++;
        if (m_tick == m_total) begin
          m_tick = 0;
          m_samps++;
          e.samp = 1'b1;
          e.sym  = (m_samps % SPS) == 0;
          m_div = int'(DIV);
          m_total = TOT[RATE];
        end else begin
          e.shift = 1'b1;
        end
      end
    end
    e.idx = m_tick;
    sb.push_back(e);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(posedge CLOCK);
      #2;
    end
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (m_tick != target && guard < 5000) begin
      cyc(1);
      guard++;
    end
    if (m_tick != target) begin
      vectors++;
      miscompares++;
      $display("FAIL run_until: idx=%0d never reached, model at %0d", target, m_tick);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (samp !== e.samp || shift !== e.shift || sym !== e.sym || int'(idx) != e.idx) begin
          miscompares++;
          $display("FAIL strobes @%0t: got samp=%b shift=%b sym=%b idx=%0d, want samp=%b shift=%b sym=%b idx=%0d",
                   $time, samp, shift, sym, idx, e.samp, e.shift, e.sym, e.idx);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    RESET = 1'b1; ENABLE = 1'b1; DIV = 8'd0; RATE = 2'd0;
    cyc(3);
    RESET = 1'b0;
    cyc(1000);

    DIV = 8'd3;
    cyc(2200);

    DIV = 8'd0;
    run_until(50);
    RATE = 2'd2;
    cyc(300);

    RATE = 2'd0;
    run_until(10);
    ENABLE = 1'b0;
    cyc(20);
    ENABLE = 1'b1;
    cyc(300);

    run_until(100);
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    cyc(300);

`ifdef SAMPCLK_SYNC_EN
    DIV = 8'd1;
    cyc(300);
    run_until(60);
    SYNC = 1'b1;
    cyc(1);
    SYNC = 1'b0;
    cyc(254 * 5);
`endif

    repeat (3000) begin
      RESET  = ($urandom_range(0, 499) == 0);
      ENABLE = ($urandom_range(0, 9) != 0);
      DIV    = 8'($urandom_range(0, 2));
      RATE   = 2'($urandom_range(0, 3));
`ifdef SAMPCLK_SYNC_EN
      SYNC   = ($urandom_range(0, 199) == 0);
`endif
      cyc(1);
    end
    RESET = 1'b0; SYNC = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge CLOCK);
      #2;
      guard++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
